// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter: state encoding and the
// round-robin pick used by the requester selector.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int MAX_REQ        = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // First valid index found scanning ptr, ptr+1, ... modulo n (n <= MAX_REQ).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    int         c;
    logic [2:0] cidx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      c    = (int'(ptr) + k) % n;
      cidx = 3'(c);
      if (k < n && !found && valid[cidx]) begin
        rr_pick = cidx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle: producers drive valid/data/last,
// the arbiter answers with a per-requester ready.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave  (input req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: returns the first valid requester at or
// after ptr, plus whether any requester is valid at all.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [2:0] pick;

  assign pick = rr_pick(MAX_REQ'(valid), 3'(ptr), NUM_REQ);
  assign idx  = IDX_W'(pick);
  assign any  = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port among NUM_REQ byte producers with
// round-robin, packet-locked grants released on last, burst limit or idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_BURST    = 16,
  parameter  int IDLE_TIMEOUT = 64,
  localparam int IDX_W        = $clog2(NUM_REQ),
  localparam int BC_W         = $clog2(MAX_BURST + 1),
  localparam int IC_W         = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                  UCLK,
  input  logic                  reset_n,
  uart_tx_arbiter_if.slave      req_if,
  output logic [DATA_WIDTH-1:0] W_data,
  output logic                  wr_uart,
  input  logic                  tx_full,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  arb_state_t            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [IDX_W-1:0]      next_ptr;
  logic [BC_W-1:0]       byte_cnt;
  logic [IC_W-1:0]       idle_cnt;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid (req_if.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) own_data = req_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign own_valid = req_if.req_valid[grant_id];
  assign own_last  = req_if.req_last[grant_id];
  assign busy      = (state == LOCK);
  // Outputs derive from the state register so reset clears them without a clock edge.
  assign wr_uart   = busy & own_valid & ~tx_full;
  assign W_data    = busy ? own_data : '0;
  assign next_ptr  = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_if.req_ready = '0;
    if (busy && !tx_full) req_if.req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge UCLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            byte_cnt <= '0;
            idle_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (wr_uart) begin
            idle_cnt <= '0;
            if (own_last || byte_cnt == BC_W'(MAX_BURST - 1)) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end else if (byte_cnt != BC_W'(MAX_BURST)) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (!own_valid) begin
            // A full FIFO with valid data is a stall, not idleness; only missing data counts.
            if (idle_cnt == IC_W'(IDLE_TIMEOUT - 1)) begin
              state       <= IDLE;
              rr_ptr      <= next_ptr;
              timeout_err <= 1'b1;
            end else if (idle_cnt != IC_W'(IDLE_TIMEOUT)) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a packet-level reference model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IT = 64;

  logic          UCLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          tx_full = 1'b0;
  logic [DW-1:0] W_data;
  logic          wr_uart;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) rif ();

  uart_tx_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
  ) dut (
    .UCLK        (UCLK),
    .reset_n     (reset_n),
    .req_if      (rif.slave),
    .W_data      (W_data),
    .wr_uart     (wr_uart),
    .tx_full     (tx_full),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 UCLK = ~UCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Producer side: per-requester byte queues of {last, data}, plus a valid enable.
  logic [8:0]    txq [NR][$];
  logic [NR-1:0] en;

  // Reference model: owner is -1 while no grant is held.
  int m_owner, m_gid, m_next, m_sent, m_idle;
  bit m_tmo;

  int            glog [$];
  logic [DW-1:0] obs  [$];
  int            tmo_cnt;

  function automatic int glog_at(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  function automatic int obs_at(input int k);
    return (k < obs.size()) ? int'(obs[k]) : 'hFFFF;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_next = 0; m_sent = 0; m_idle = 0; m_tmo = 0;
  endtask

  // One clock: drive inputs, compare against model, advance model. Entered and left at negedge.
  task automatic step();
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    logic             busy_e, wr_e;
    logic [NR-1:0]    rdy_e;
    logic [DW-1:0]    wd_e;
    for (int i = 0; i < NR; i++) begin
      v[i] = en[i] && (txq[i].size() > 0);
      if (txq[i].size() > 0) begin
        l[i] = txq[i][0][8];
        d[i*DW +: DW] = txq[i][0][7:0];
      end else begin
        l[i] = 1'b0;
        d[i*DW +: DW] = 8'($urandom);
      end
    end
    rif.req_valid = v;
    rif.req_last  = l;
    rif.req_data  = d;
    #1;
    busy_e = (m_owner >= 0);
    wr_e   = busy_e && v[m_owner] && !tx_full;
    rdy_e  = (busy_e && !tx_full) ? NR'(1 << m_owner) : '0;
    wd_e   = busy_e ? d[m_owner*DW +: DW] : '0;
    check("busy", busy, busy_e);
    check("wr_uart", wr_uart, wr_e);
    check("req_ready", rif.req_ready, rdy_e);
    check("W_data", W_data, wd_e);
    check("grant_id", grant_id, m_gid);
    check("timeout_err", timeout_err, m_tmo);
    if (wr_uart === 1'b1) obs.push_back(W_data);
    if (timeout_err === 1'b1) tmo_cnt++;
    m_tmo = 0;
    if (!busy_e) begin
      for (int k = NR - 1; k >= 0; k--) begin
        if (v[(m_next + k) % NR]) m_owner = (m_next + k) % NR;
      end
      if (m_owner >= 0) begin
        m_gid = m_owner; m_sent = 0; m_idle = 0;
        glog.push_back(m_owner);
      end
    end else if (wr_e) begin
      void'(txq[m_owner].pop_front());
      m_sent++;
      m_idle = 0;
      if (l[m_owner] || m_sent == MB) begin
        m_next = (m_owner + 1) % NR; m_owner = -1;
      end
    end else if (!v[m_owner]) begin
      m_idle++;
      if (m_idle == IT) begin
        m_next = (m_owner + 1) % NR; m_owner = -1; m_tmo = 1;
      end
    end
    @(negedge UCLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NR; i++) txq[i].delete();
    en = '0;
    tx_full = 1'b0;
    rif.req_valid = '0;
    rif.req_data  = '0;
    rif.req_last  = '0;
    glog.delete();
    obs.delete();
    tmo_cnt = 0;
    model_reset();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_stim();
    @(negedge UCLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_uart", wr_uart, 0);
    check("rst_req_ready", rif.req_ready, 0);
    check("rst_W_data", W_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(negedge UCLK);
    reset_n = 1'b1;
  endtask

  int stall [NR];

  initial begin
    // Single owner: two-byte packet from requester 2.
    do_reset();
    txq[2].push_back(9'h0AA);
    txq[2].push_back(9'h155);
    en = '1;
    run(6);
    check("single_grant", glog_at(0), 2);
    check("single_nbytes", obs.size(), 2);
    check("single_b0", obs_at(0), 'hAA);
    check("single_b1", obs_at(1), 'h55);

    // Round-robin: every requester holds two one-byte packets.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      txq[i].push_back({1'b1, 8'(8'h10 + i)});
      txq[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    en = '1;
    run(18);
    for (int k = 0; k < 5; k++) check("rr_order", glog_at(k), k % NR);
    check("rr_nbytes", obs.size(), 8);

    // Backpressure during a three-byte packet.
    do_reset();
    txq[1].push_back(9'h011);
    txq[1].push_back(9'h022);
    txq[1].push_back(9'h133);
    en = '1;
    for (int c = 0; c < 12; c++) begin
      tx_full = (c >= 2 && c < 7);
      step();
    end
    tx_full = 1'b0;
    check("bp_nbytes", obs.size(), 3);
    check("bp_b0", obs_at(0), 'h11);
    check("bp_b1", obs_at(1), 'h22);
    check("bp_b2", obs_at(2), 'h33);
    check("bp_no_timeout", tmo_cnt, 0);

    // Forced release after MAX_BURST bytes with requester 3 waiting.
    do_reset();
    for (int b = 1; b <= 20; b++) txq[1].push_back({1'b0, 8'(b)});
    txq[3].push_back(9'h1C3);
    en = '1;
    run(110);
    check("burst_g0", glog_at(0), 1);
    check("burst_g1", glog_at(1), 3);
    check("burst_g2", glog_at(2), 1);
    check("burst_b15", obs_at(15), 16);
    check("burst_b16", obs_at(16), 'hC3);
    check("burst_b17", obs_at(17), 17);
    check("burst_nbytes", obs.size(), 21);
    check("burst_timeouts", tmo_cnt, 1);

    // Timeout: one byte without last, then silence.
    do_reset();
    txq[0].push_back(9'h012);
    en = '1;
    run(66);
    check("tmo_before", tmo_cnt, 0);
    run(10);
    check("tmo_pulses", tmo_cnt, 1);
    check("tmo_busy", busy, 0);

    // Asynchronous reset mid-packet.
    do_reset();
    for (int b = 0; b < 5; b++) txq[2].push_back({1'b0, 8'(8'h60 + b)});
    en = '1;
    run(3);
    #2;
    check("ares_pre_wr", wr_uart, 1);
    reset_n = 1'b0;
    #1;
    check("ares_wr_uart", wr_uart, 0);
    check("ares_busy", busy, 0);
    check("ares_req_ready", rif.req_ready, 0);
    check("ares_grant_id", grant_id, 0);
    clear_stim();
    for (int i = 0; i < NR; i++) txq[i].push_back({1'b1, 8'(8'h70 + i)});
    en = '1;
    @(negedge UCLK);
    reset_n = 1'b1;
    run(10);
    check("ares_restart", glog_at(0), 0);
    check("ares_second", glog_at(1), 1);

    // Randomized traffic with drops, stalls and backpressure.
    do_reset();
    for (int i = 0; i < NR; i++) stall[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (txq[i].size() == 0 && $urandom_range(0, 9) == 0) begin
          int len;
          len = $urandom_range(1, 22);
          for (int b = 0; b < len; b++) txq[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
        if (stall[i] > 0) stall[i]--;
        else if ($urandom_range(0, 299) == 0) stall[i] = 70;
        en[i] = (stall[i] == 0) && ($urandom_range(0, 7) != 0);
      end
      tx_full = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port (W_data/wr_uart/tx_full of UART_TOP) among NUM_REQ independent byte requesters.
- Round-robin arbitration with packet locking: a grant is held until the owner presents a byte flagged last, exceeds MAX_BURST bytes, or stalls past IDLE_TIMEOUT cycles.
- Sits between on-chip producers (command/response engines, debug printers) and UART_TOP.

Parameters:
- DATA_WIDTH, 8, byte width; must match UART_TOP DATA_WIDTH.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (>=1).
- IDLE_TIMEOUT, 64, consecutive owner-idle cycles before forced release (>=2).

Ports:
- UCLK  in  1  system clock; all logic rises on posedge UCLK.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte is the final byte of the packet.
- req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready).
- W_data  out  DATA_WIDTH  to UART_TOP W_data.
- wr_uart  out  1  to UART_TOP wr_uart.
- tx_full  in  1  from UART_TOP tx_full.
- grant_id  out  clog2(NUM_REQ)  current or last owner index.
- busy  out  1  high while a grant is locked.
- timeout_err  out  1  one-cycle pulse on a timeout release.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): state=IDLE, grant_id=0, rr_ptr=0, byte_cnt=0, idle_cnt=0, timeout_err=0. Outputs: req_ready=0, wr_uart=0, W_data=0, busy=0.
- States: IDLE, LOCK.
- IDLE:
  - If any req_valid is high, select the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register it into grant_id, clear the counters, go to LOCK next cycle.
  - Arbitration latency is 1 cycle; no byte is transferred in IDLE.
- LOCK datapath (combinational, zero latency):
  - W_data = req_data[grant_id].
  - req_ready[grant_id] = !tx_full; all other req_ready bits are 0.
  - wr_uart = req_valid[grant_id] & !tx_full.
  - wr_uart is never asserted while tx_full=1, so the FIFO never overflows.
- LOCK transitions, evaluated each cycle:
  - Transfer with req_last=1: release.
  - Transfer with byte_cnt==MAX_BURST-1: release (forced fairness), even if req_last=0.
  - req_valid[grant_id]=0: idle_cnt++. When idle_cnt reaches IDLE_TIMEOUT-1, release and pulse timeout_err for 1 cycle.
  - tx_full stall while valid=1 does not advance idle_cnt. Any transfer clears idle_cnt.
  - Otherwise, each transfer increments byte_cnt.
- Release:
  - Next state IDLE, rr_ptr = grant_id+1 (wraps to 0 at NUM_REQ-1).
  - grant_id holds its value.
  - A 1-cycle bubble separates consecutive grants.
- Requests from non-owners are ignored while locked; they are not queued.
- A requester dropping valid mid-packet is legal; the lock is held until timeout.
- Reset asserted mid-packet aborts immediately. A partially written packet stays in the UART FIFO; this is a documented system-level caveat.
- byte_cnt width is clog2(MAX_BURST+1). idle_cnt width is clog2(IDLE_TIMEOUT+1). Both saturate and never wrap.

Decomposition:
- Package uart_pkg:
  - DATA_WIDTH default.
  - arb_state_t enum {IDLE, LOCK}.
  - Function rr_pick(valid, ptr) returning an index.
- Sub-module rr_arbiter: pure combinational round-robin selector (valid vector, ptr -> index, any).
- The top holds the FSM, counters and datapath mux.

Test Plan:
- Single owner:
  - Stimulus: requester 2 sends 0xAA, 0x55(last), tx_full=0.
  - Response: grant_id=2 one cycle after valid; wr_uart high for exactly 2 cycles with W_data AA then 55; busy falls the next cycle.
- Round-robin:
  - Stimulus: all 4 requesters valid, each sending 1-byte packets (last=1), starting from reset.
  - Response: grant order 0,1,2,3,0; each grant is followed by a 1-cycle bubble.
- Backpressure:
  - Stimulus: tx_full=1 for 5 cycles during a 3-byte packet.
  - Response: wr_uart=0 and req_ready=0 while full; all 3 bytes delivered in order afterward; timeout_err never pulses.
- Forced release:
  - Stimulus: MAX_BURST=16, requester 1 streams 20 bytes with no last, requester 3 is waiting.
  - Response: release after byte 16, requester 3 is granted next, requester 1 resumes later at byte 17.
- Timeout:
  - Stimulus: requester 0 sends 1 byte (last=0) then drops valid.
  - Response: after IDLE_TIMEOUT=64 idle cycles, timeout_err pulses once and busy=0.
- Async reset:
  - Stimulus: reset_n pulled low mid-packet, between clock edges.
  - Response: wr_uart, req_ready and busy go to 0 immediately without waiting for a clock edge; after release, arbitration restarts from requester 0.
